// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - EX-stage sequencer for the multi-cycle DIV/DIVU divider core
//
// Accepts a divide request from EX, latches operands and the PC tag, launches
// the divider core and stalls EX until the {remainder, quotient} result is
// ready. The request retires when the pipeline advances. A flush, or a
// different instruction showing up in EX, annuls an in-flight divide.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   ex_req_i          EX holds DIV/DIVU
//   ex_signed_i       1 = DIV, 0 = DIVU
//   ex_pc_i           PC of the EX instruction (request tag)
//   ex_dividend_i     rs value
//   ex_divisor_i      rt value
//   flush_i           pipeline flush, cancels everything
//   pipe_advance_i    EX/MEM captures EX this cycle
//   stall_o           EX stall request (combinational)
//   result_valid_o    result_o valid for the tagged request
//   result_o          {remainder, quotient}; HI = [63:32], LO = [31:0]
//   div_start_o       one-cycle launch pulse to the core
//   div_signed_o      latched signedness
//   div_op1_o         latched dividend
//   div_op2_o         latched divisor
//   div_annul_o       one-cycle abort pulse to the core
//   div_done_i        core finished, div_result_i valid
//   div_result_i      {remainder, quotient} from the core
`timescale 1ns/1ps

module div_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_req_i,
    input  logic        ex_signed_i,
    input  logic [31:0] ex_pc_i,
    input  logic [31:0] ex_dividend_i,
    input  logic [31:0] ex_divisor_i,
    input  logic        flush_i,
    input  logic        pipe_advance_i,
    output logic        stall_o,
    output logic        result_valid_o,
    output logic [63:0] result_o,
    output logic        div_start_o,
    output logic        div_signed_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    output logic        div_annul_o,
    input  logic        div_done_i,
    input  logic [63:0] div_result_i
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_tag;
    logic        r_signed;
    logic [31:0] r_op1;
    logic [31:0] r_op2;
    logic [63:0] r_result;
    logic        r_start_q;
    logic        r_annul_q;

    logic        w_pc_match;
    logic        w_div_zero;
    logic        w_same_instr;

    assign w_pc_match   = (ex_pc_i == r_tag);
    assign w_div_zero   = (ex_divisor_i == 32'd0);
    // The instruction that owns the latched request is still sitting in EX.
    assign w_same_instr = ex_req_i & w_pc_match;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_tag     <= 32'd0;
            r_signed  <= 1'b0;
            r_op1     <= 32'd0;
            r_op2     <= 32'd0;
            r_result  <= 64'd0;
            r_start_q <= 1'b0;
            r_annul_q <= 1'b0;
        end else begin
            // Launch and annul are single-cycle pulses.
            r_start_q <= 1'b0;
            r_annul_q <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (ex_req_i && !flush_i) begin
                        r_tag    <= ex_pc_i;
                        r_signed <= ex_signed_i;
                        r_op1    <= ex_dividend_i;
                        r_op2    <= ex_divisor_i;
                        if (w_div_zero) begin
                            // MIPS leaves divide-by-zero undefined; we report
                            // HI = dividend, LO = all ones without using the core.
                            r_result <= {ex_dividend_i, 32'hFFFF_FFFF};
                            r_state  <= ST_DONE;
                        end else begin
                            r_start_q <= 1'b1;
                            r_state   <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    // Abort takes priority over a coincident done so that a
                    // flushed divide never writes HI/LO.
                    if (flush_i || !w_same_instr) begin
                        r_annul_q <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else if (div_done_i) begin
                        r_result <= div_result_i;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (flush_i) begin
                        r_state <= ST_IDLE;
                    end else if (w_same_instr && pipe_advance_i) begin
                        r_state <= ST_IDLE;
                    end else if (!w_same_instr) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Only the tagged instruction is released in DONE; a different divide in
    // EX keeps stalling until it has been accepted and computed.
    assign stall_o        = ex_req_i & ~flush_i & ~((r_state == ST_DONE) & w_pc_match);
    assign result_valid_o = (r_state == ST_DONE);
    assign result_o       = r_result;
    assign div_start_o    = r_start_q;
    assign div_annul_o    = r_annul_q;
    assign div_signed_o   = r_signed;
    assign div_op1_o      = r_op1;
    assign div_op2_o      = r_op2;

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - directed, table-driven self-checking bench for div_ctrl
`timescale 1ns/1ps

module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_req_i;
    logic        ex_signed_i;
    logic [31:0] ex_pc_i;
    logic [31:0] ex_dividend_i;
    logic [31:0] ex_divisor_i;
    logic        flush_i;
    logic        pipe_advance_i;
    logic        stall_o;
    logic        result_valid_o;
    logic [63:0] result_o;
    logic        div_start_o;
    logic        div_signed_o;
    logic [31:0] div_op1_o;
    logic [31:0] div_op2_o;
    logic        div_annul_o;
    logic        div_done_i;
    logic [63:0] div_result_i;

    div_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .ex_req_i       (ex_req_i),
        .ex_signed_i    (ex_signed_i),
        .ex_pc_i        (ex_pc_i),
        .ex_dividend_i  (ex_dividend_i),
        .ex_divisor_i   (ex_divisor_i),
        .flush_i        (flush_i),
        .pipe_advance_i (pipe_advance_i),
        .stall_o        (stall_o),
        .result_valid_o (result_valid_o),
        .result_o       (result_o),
        .div_start_o    (div_start_o),
        .div_signed_o   (div_signed_o),
        .div_op1_o      (div_op1_o),
        .div_op2_o      (div_op2_o),
        .div_annul_o    (div_annul_o),
        .div_done_i     (div_done_i),
        .div_result_i   (div_result_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic        sgn;
        logic [31:0] pc;
        logic [31:0] dvd;
        logic [31:0] dvs;
        logic        flush;
        logic        adv;
        logic        done;
        logic [63:0] dres;
        logic        e_stall;
        logic        e_valid;
        logic [63:0] e_res;
        logic        e_start;
        logic        e_annul;
        logic [31:0] e_op1;
        logic [31:0] e_op2;
        logic        e_sgn;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic vec_t mk(
        input logic req, input logic sgn, input logic [31:0] pc,
        input logic [31:0] dvd, input logic [31:0] dvs, input logic flush,
        input logic adv, input logic done, input logic [63:0] dres,
        input logic e_stall, input logic e_valid, input logic [63:0] e_res,
        input logic e_start, input logic e_annul, input logic [31:0] e_op1,
        input logic [31:0] e_op2, input logic e_sgn);
        vec_t v;
        v.req = req; v.sgn = sgn; v.pc = pc; v.dvd = dvd; v.dvs = dvs;
        v.flush = flush; v.adv = adv; v.done = done; v.dres = dres;
        v.e_stall = e_stall; v.e_valid = e_valid; v.e_res = e_res;
        v.e_start = e_start; v.e_annul = e_annul; v.e_op1 = e_op1;
        v.e_op2 = e_op2; v.e_sgn = e_sgn;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic req, input logic sgn, input logic [31:0] pc,
                         input logic [31:0] dvd, input logic [31:0] dvs,
                         input logic flush, input logic adv, input logic done,
                         input logic [63:0] dres);
        ex_req_i       = req;
        ex_signed_i    = sgn;
        ex_pc_i        = pc;
        ex_dividend_i  = dvd;
        ex_divisor_i   = dvs;
        flush_i        = flush;
        pipe_advance_i = adv;
        div_done_i     = done;
        div_result_i   = dres;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] PA = 32'h0000_0100;
    localparam logic [31:0] PB = 32'h0000_0200;
    localparam logic [31:0] PC = 32'h0000_0300;
    localparam logic [31:0] PD = 32'h0000_0400;
    localparam logic [31:0] PE = 32'h0000_0500;
    localparam logic [63:0] R1 = {32'd2, 32'd14};
    localparam logic [63:0] RZ = 64'h1234_5678_FFFF_FFFF;
    localparam logic [63:0] R9 = 64'h0000_0009_FFFF_FFFF;
    localparam logic [63:0] R8 = 64'h0000_0008_FFFF_FFFF;

    vec_t tbl [20];

    initial begin
        int n_start;
        int n_annul;
        int n_stall;
        int n_valid;

        // Normal divide with N=1, then divide-by-zero, flush racing done,
        // and back-to-back divide-by-zero at different PCs leaving DONE.
        tbl[0]  = mk(0,0,0, 0,0, 0,0,0,0,          0,0,0, 0,0, 0,0,0);
        tbl[1]  = mk(1,0,PA,100,7, 0,0,0,0,        1,0,0, 0,0, 0,0,0);
        tbl[2]  = mk(1,0,PA,100,7, 0,0,0,0,        1,0,0, 1,0, 100,7,0);
        tbl[3]  = mk(1,0,PA,100,7, 0,0,1,R1,       1,0,0, 0,0, 100,7,0);
        tbl[4]  = mk(1,0,PA,100,7, 0,1,0,0,        0,1,R1, 0,0, 100,7,0);
        tbl[5]  = mk(0,0,0, 0,0, 0,0,0,0,          0,0,R1, 0,0, 100,7,0);
        tbl[6]  = mk(1,0,PB,32'h1234_5678,0, 0,0,0,0, 1,0,R1, 0,0, 100,7,0);
        tbl[7]  = mk(1,0,PB,32'h1234_5678,0, 0,1,0,0, 0,1,RZ, 0,0, 32'h1234_5678,0,0);
        tbl[8]  = mk(0,0,0, 0,0, 0,0,0,0,          0,0,RZ, 0,0, 32'h1234_5678,0,0);
        tbl[9]  = mk(1,1,PC,50,5, 0,0,0,0,         1,0,RZ, 0,0, 32'h1234_5678,0,0);
        tbl[10] = mk(1,1,PC,50,5, 0,0,0,0,         1,0,RZ, 1,0, 50,5,1);
        tbl[11] = mk(1,1,PC,50,5, 1,0,1,64'hDEAD,  0,0,RZ, 0,0, 50,5,1);
        tbl[12] = mk(0,0,0, 0,0, 0,0,0,0,          0,0,RZ, 0,1, 50,5,1);
        tbl[13] = mk(0,0,0, 0,0, 0,0,0,0,          0,0,RZ, 0,0, 50,5,1);
        tbl[14] = mk(1,0,PD,9,0, 0,0,0,0,          1,0,RZ, 0,0, 50,5,1);
        tbl[15] = mk(1,0,PD,9,0, 0,0,0,0,          0,1,R9, 0,0, 9,0,0);
        tbl[16] = mk(1,0,PE,8,0, 0,0,0,0,          1,1,R9, 0,0, 9,0,0);
        tbl[17] = mk(1,0,PE,8,0, 0,0,0,0,          1,0,R9, 0,0, 9,0,0);
        tbl[18] = mk(1,0,PE,8,0, 0,1,0,0,          0,1,R8, 0,0, 8,0,0);
        tbl[19] = mk(0,0,0, 0,0, 0,0,0,0,          0,0,R8, 0,0, 8,0,0);

        rst = 1'b0;
        drive(0,0,0,0,0,0,0,0,0);
        #12;
        chk("rst_stall",  {63'd0, stall_o}, 64'd0);
        chk("rst_valid",  {63'd0, result_valid_o}, 64'd0);
        chk("rst_result", result_o, 64'd0);
        chk("rst_start",  {63'd0, div_start_o}, 64'd0);
        chk("rst_annul",  {63'd0, div_annul_o}, 64'd0);
        chk("rst_op1",    {32'd0, div_op1_o}, 64'd0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].req, tbl[i].sgn, tbl[i].pc, tbl[i].dvd, tbl[i].dvs,
                  tbl[i].flush, tbl[i].adv, tbl[i].done, tbl[i].dres);
            #2;
            chk($sformatf("tbl%0d_stall", i), {63'd0, stall_o}, {63'd0, tbl[i].e_stall});
            chk($sformatf("tbl%0d_valid", i), {63'd0, result_valid_o}, {63'd0, tbl[i].e_valid});
            chk($sformatf("tbl%0d_result", i), result_o, tbl[i].e_res);
            chk($sformatf("tbl%0d_start", i), {63'd0, div_start_o}, {63'd0, tbl[i].e_start});
            chk($sformatf("tbl%0d_annul", i), {63'd0, div_annul_o}, {63'd0, tbl[i].e_annul});
            chk($sformatf("tbl%0d_op1", i), {32'd0, div_op1_o}, {32'd0, tbl[i].e_op1});
            chk($sformatf("tbl%0d_op2", i), {32'd0, div_op2_o}, {32'd0, tbl[i].e_op2});
            chk($sformatf("tbl%0d_sgn", i), {63'd0, div_signed_o}, {63'd0, tbl[i].e_sgn});
            tick();
        end

        // Signed -7 / 2 with a 32-cycle core: quotient -3, remainder -1.
        n_start = 0; n_stall = 0; n_valid = 0;
        for (int c = 0; c <= 36; c++) begin
            drive(c < 35, 1, 32'hBFC0_0100, 32'hFFFF_FFF9, 32'd2, 0, 1, c == 33,
                  64'hFFFF_FFFF_FFFF_FFFD);
            #2;
            if (stall_o) n_stall++;
            if (div_start_o) begin
                n_start++;
                chk("sdiv_start_cycle", c, 1);
            end
            if (result_valid_o) begin
                n_valid++;
                chk("sdiv_valid_cycle", c, 34);
                chk("sdiv_result", result_o, 64'hFFFF_FFFF_FFFF_FFFD);
            end
            tick();
        end
        chk("sdiv_n_start", n_start, 1);
        chk("sdiv_n_stall", n_stall, 34);
        chk("sdiv_n_valid", n_valid, 1);

        // Flush at T+10 of a 32-cycle divide; late done at T+33 is ignored.
        n_start = 0; n_annul = 0; n_valid = 0;
        for (int c = 0; c <= 36; c++) begin
            drive(c <= 10, 0, 32'hBFC0_0100, 32'd1000, 32'd10, c == 10, 1, c == 33,
                  64'h1111_2222_3333_4444);
            #2;
            if (div_start_o) n_start++;
            if (div_annul_o) begin
                n_annul++;
                chk("flush_annul_cycle", c, 11);
            end
            if (result_valid_o) n_valid++;
            tick();
        end
        chk("flush_n_start", n_start, 1);
        chk("flush_n_annul", n_annul, 1);
        chk("flush_n_valid", n_valid, 0);
        chk("flush_result_kept", result_o, 64'hFFFF_FFFF_FFFF_FFFD);

        // PC change mid-BUSY, then 5 cycles of downstream stall in DONE.
        n_start = 0; n_annul = 0;
        for (int c = 0; c <= 15; c++) begin
            drive(c < 15, 1, (c < 5) ? 32'hBFC0_0100 : 32'hBFC0_0200,
                  (c < 5) ? 32'd100 : 32'd200, (c < 5) ? 32'd3 : 32'd4,
                  0, c >= 14, c == 8, 64'h0000_0000_0000_0032);
            #2;
            if (div_start_o) n_start++;
            if (div_annul_o) n_annul++;
            if (c == 5) chk("chg_stall_mismatch", {63'd0, stall_o}, 64'd1);
            if (c == 6) chk("chg_annul", {63'd0, div_annul_o}, 64'd1);
            if (c == 7) begin
                chk("chg_restart", {63'd0, div_start_o}, 64'd1);
                chk("chg_op1", {32'd0, div_op1_o}, 64'd200);
                chk("chg_op2", {32'd0, div_op2_o}, 64'd4);
            end
            if (c >= 9 && c <= 14) begin
                chk($sformatf("hold%0d_valid", c), {63'd0, result_valid_o}, 64'd1);
                chk($sformatf("hold%0d_stall", c), {63'd0, stall_o}, 64'd0);
                chk($sformatf("hold%0d_result", c), result_o, 64'h32);
            end
            if (c == 15) chk("hold_retired", {63'd0, result_valid_o}, 64'd0);
            tick();
        end
        chk("chg_n_start", n_start, 2);
        chk("chg_n_annul", n_annul, 1);

        // Asynchronous reset in the first BUSY cycle, between clock edges.
        drive(1, 1, 32'h600, 32'd77, 32'd7, 0, 1, 0, 0);
        tick();
        #2;
        chk("arst_pre_start", {63'd0, div_start_o}, 64'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_start",  {63'd0, div_start_o}, 64'd0);
        chk("arst_valid",  {63'd0, result_valid_o}, 64'd0);
        chk("arst_result", result_o, 64'd0);
        chk("arst_annul",  {63'd0, div_annul_o}, 64'd0);
        chk("arst_op1",    {32'd0, div_op1_o}, 64'd0);
        chk("arst_sgn",    {63'd0, div_signed_o}, 64'd0);
        chk("arst_stall_req", {63'd0, stall_o}, 64'd1);
        ex_req_i = 1'b0;
        #1;
        chk("arst_stall_idle", {63'd0, stall_o}, 64'd0);
        rst = 1'b1;
        tick();
        drive(1, 0, 32'h700, 32'd21, 32'd4, 0, 1, 0, 0);
        #2;
        chk("post_rst_stall", {63'd0, stall_o}, 64'd1);
        tick();
        #2;
        chk("post_rst_start", {63'd0, div_start_o}, 64'd1);
        chk("post_rst_op1", {32'd0, div_op1_o}, 64'd21);
        tick();
        drive(1, 0, 32'h700, 32'd21, 32'd4, 0, 1, 1, {32'd1, 32'd5});
        tick();
        drive(1, 0, 32'h700, 32'd21, 32'd4, 0, 1, 0, 0);
        #2;
        chk("post_rst_valid", {63'd0, result_valid_o}, 64'd1);
        chk("post_rst_result", result_o, {32'd1, 32'd5});
        chk("post_rst_nostall", {63'd0, stall_o}, 64'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("post_rst_retired", {63'd0, result_valid_o}, 64'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
